// File: rtl/nn_pkg.sv
// nn_pkg - shared types and defaults for the dot-product sequencer slice.
//   state_t : sequencer FSM states
//   DEF_*   : default widths and MAC pipeline latency
//   data_t  : signed operand / result type at the default width
package nn_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEN_W   = 8;
  localparam int DEF_MAC_LAT = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic signed [DEF_DATA_W-1:0] data_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if - scheduler-facing handshakes of the dot-product sequencer.
//   cmd_*   : command channel (valid/ready + length)
//   abort   : synchronous abort of the running command
//   op_*    : operand-pair stream (valid/ready + a/b)
//   res_*   : result channel (valid/ready + data)
//   master  : scheduler side, slave : sequencer side
interface mac_seq_ctrl_if
  import nn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic              abort;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  modport master (
    output cmd_valid, cmd_len, abort, op_valid, op_a, op_b, res_ready,
    input  cmd_ready, op_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_len, abort, op_valid, op_a, op_b, res_ready,
    output cmd_ready, op_ready, res_valid, res_data
  );

endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl - sequences an external MAC through one signed dot product
// of cmd_len operand pairs and returns the wrapped accumulator value.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bus        : command / operand / result handshakes (slave modport)
//   mac_clr    : clear pulse for the MAC accumulator
//   mac_enable : MAC accumulate enable, one cycle per accepted beat
//   mac_a/b    : registered operands to the MAC
//   mac_out    : MAC accumulator value
//   busy       : high whenever not idle
// All outputs are registered.
module mac_seq_ctrl
  import nn_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input  logic              clk,
  input  logic              reset,
  mac_seq_ctrl_if.slave     bus,
  output logic              mac_clr,
  output logic              mac_enable,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  input  logic [DATA_W-1:0] mac_out,
  output logic              busy
);

  // Drain counter only needs to reach MAC_LAT.
  localparam int DC_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  state_t            state_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  cnt_reg;
  logic [DC_W-1:0]   drain_reg;
  logic              cmd_ready_reg;
  logic              op_ready_reg;
  logic              res_valid_reg;
  logic [DATA_W-1:0] res_data_reg;

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.op_ready  = op_ready_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      cnt_reg       <= '0;
      drain_reg     <= '0;
      cmd_ready_reg <= 1'b1;
      op_ready_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      mac_clr       <= 1'b0;
      mac_enable    <= 1'b0;
      mac_a         <= '0;
      mac_b         <= '0;
      busy          <= 1'b0;
    end else begin
      // Clear and enable are single-cycle pulses unless re-asserted below.
      mac_clr    <= 1'b0;
      mac_enable <= 1'b0;

      if (bus.abort && (state_reg inside {CLEAR, RUN, DRAIN})) begin
        // Abort wins over any beat offered on the same edge; the clear
        // pulse leaves the MAC clean even if a beat was already in flight.
        state_reg     <= IDLE;
        mac_clr       <= 1'b1;
        op_ready_reg  <= 1'b0;
        cmd_ready_reg <= 1'b1;
        busy          <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            // Zero-length commands are consumed without leaving IDLE.
            if (bus.cmd_valid && (bus.cmd_len != '0)) begin
              state_reg     <= CLEAR;
              len_reg       <= bus.cmd_len;
              cnt_reg       <= '0;
              cmd_ready_reg <= 1'b0;
              busy          <= 1'b1;
              mac_clr       <= 1'b1;
            end
          end
          CLEAR: begin
            // len >= 1, so at least one beat is always wanted.
            state_reg    <= RUN;
            op_ready_reg <= 1'b1;
          end
          RUN: begin
            if (bus.op_valid) begin
              mac_a      <= bus.op_a;
              mac_b      <= bus.op_b;
              mac_enable <= 1'b1;
              cnt_reg    <= cnt_reg + LEN_W'(1);
              if ((cnt_reg + LEN_W'(1)) == len_reg) begin
                state_reg    <= DRAIN;
                op_ready_reg <= 1'b0;
                drain_reg    <= '0;
              end
            end
          end
          DRAIN: begin
            // Capture once the MAC has had MAC_LAT edges past sampling
            // the final beat.
            if (drain_reg == DC_W'(MAC_LAT)) begin
              state_reg     <= DONE;
              res_data_reg  <= mac_out;
              res_valid_reg <= 1'b1;
            end else begin
              drain_reg <= drain_reg + DC_W'(1);
            end
          end
          DONE: begin
            if (bus.res_ready) begin
              state_reg     <= IDLE;
              res_valid_reg <= 1'b0;
              cmd_ready_reg <= 1'b1;
              busy          <= 1'b0;
            end
          end
          default: begin
            state_reg     <= IDLE;
            op_ready_reg  <= 1'b0;
            res_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            busy          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl - drives mac_seq_ctrl with directed and random dot-product
// commands against a behavioural MAC and an arithmetic reference.
module tb_mac_seq_ctrl;
  import nn_pkg::*;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int ML = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

  logic          mac_clr;
  logic          mac_enable;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic [DW-1:0] mac_out;
  logic [DW-1:0] acc;
  logic          busy;

  mac_seq_ctrl #(.DATA_W(DW), .LEN_W(LW), .MAC_LAT(ML)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mac_clr    (mac_clr),
    .mac_enable (mac_enable),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_out    (mac_out),
    .busy       (busy)
  );

  // Behavioural MAC: clear has priority, accumulate wraps at DW bits.
  always @(posedge clk) begin
    if (mac_clr)         acc <= '0;
    else if (mac_enable) acc <= acc + mac_a * mac_b;
  end
  assign mac_out = acc;

  int tests_run = 0;
  int tests_failed = 0;
  int last_wait;
  logic [DW-1:0] opa [256];
  logic [DW-1:0] opb [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference dot product: plain integer arithmetic, wrapped to DW bits.
  function automatic logic [DW-1:0] dot(input int len);
    int s;
    s = 0;
    for (int i = 0; i < len; i++) s += int'($signed(opa[i])) * int'($signed(opb[i]));
    return s[DW-1:0];
  endfunction

  task automatic set_pair(input int i, input int a, input int b);
    opa[i] = DW'(a);
    opb[i] = DW'(b);
  endtask

  task automatic start_cmd(input int len);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", 32'(n < 20), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = LW'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("clr_pulse", 32'(mac_clr), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic feed_beat(input int i);
    int n;
    bus.op_valid = 1'b1;
    bus.op_a = opa[i];
    bus.op_b = opb[i];
    n = 0;
    while (!bus.op_ready && n < 20) begin @(negedge clk); n++; end
    chk("op_ready_wait", 32'(n < 20), 32'd1);
    last_wait = n;
    @(negedge clk);
    bus.op_valid = 1'b0;
    chk("beat_en", 32'(mac_enable), 32'd1);
    chk("beat_ab", 32'({mac_a, mac_b}), 32'({opa[i], opb[i]}));
  endtask

  task automatic do_cmd(input int len, input int gap, input int stall);
    int n;
    logic [DW-1:0] exp_v;
    logic [DW-1:0] held;
    exp_v = dot(len);
    start_cmd(len);
    for (int i = 0; i < len; i++) begin
      feed_beat(i);
      if (i == 0) begin
        chk("clear_one_cycle", 32'(last_wait), 32'd1);
        chk("clr_dropped", 32'(mac_clr), 32'd0);
      end
      if (i != len - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("gap_en_low", 32'(mac_enable), 32'd0);
        end
      end
    end
    n = 0;
    while (!bus.res_valid && n < 50) begin @(negedge clk); n++; end
    chk("res_latency", 32'(n), 32'(1 + ML));
    chk("res_data", 32'(bus.res_data), 32'(exp_v));
    held = bus.res_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_hold", 32'({bus.res_valid, bus.cmd_ready, bus.res_data}),
          32'({1'b1, 1'b0, held}));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_consumed", 32'({bus.res_valid, bus.cmd_ready, busy}), 32'({1'b0, 1'b1, 1'b0}));
    $display("[TB] cmd len=%0d gap=%0d stall=%0d res=%0d exp=%0d", len, gap, stall,
             $signed(held), $signed(exp_v));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, 32'({bus.cmd_ready, bus.op_ready, mac_clr, mac_enable, bus.res_valid, busy}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    chk({tag, "_data"}, 32'({mac_a, mac_b, bus.res_data}), 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.res_ready = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #2 chk_reset_vals("reset_state");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Basic dot product = 75.
    set_pair(0, 1, 5); set_pair(1, 4, 10); set_pair(2, 12, 2); set_pair(3, 2, 3);
    do_cmd(4, 0, 0);
    // Same operands with gaps and a stalled consumer.
    do_cmd(4, 3, 5);

    // Signed operands = -26.
    set_pair(0, 1, -1); set_pair(1, -1, 1); set_pair(2, -1, -2);
    set_pair(3, -20, 2); set_pair(4, -7, -2);
    do_cmd(5, 0, 0);

    // Back-to-back: 9 then 5.
    set_pair(0, 3, 3);
    do_cmd(1, 0, 0);
    set_pair(0, 2, 2); set_pair(1, 1, 1);
    do_cmd(2, 0, 0);

    // Zero-length command is ignored.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = '0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("len0_ignored", 32'({bus.cmd_ready, busy, mac_clr}), 32'({1'b1, 1'b0, 1'b0}));
    repeat (3) begin
      @(negedge clk);
      chk("len0_no_res", 32'(bus.res_valid), 32'd0);
    end
    $display("[TB] cmd len=0 ignored");

    // Abort after 2 of 4 beats, with a beat offered on the abort edge.
    set_pair(0, 1, 1); set_pair(1, 2, 2); set_pair(2, 3, 3); set_pair(3, 4, 4);
    start_cmd(4);
    feed_beat(0);
    feed_beat(1);
    bus.op_valid = 1'b1;
    bus.op_a = 8'd5;
    bus.op_b = 8'd5;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.op_valid = 1'b0;
    chk("abort_state", 32'({busy, bus.cmd_ready, mac_clr, mac_enable, bus.op_ready}),
        32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0}));
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_res", 32'(bus.res_valid), 32'd0);
    end
    $display("[TB] abort after 2 beats");
    set_pair(0, -4, 3);
    do_cmd(1, 0, 0);

    // Reset asserted between edges in the middle of RUN.
    set_pair(0, 7, 7); set_pair(1, 7, 7); set_pair(2, 7, 7);
    start_cmd(3);
    feed_beat(0);
    #2 reset = 1'b0;
    #1 chk_reset_vals("midrun_reset");
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset mid-run");
    set_pair(0, 5, 5); set_pair(1, 1, -1);
    do_cmd(2, 0, 0);

    // Random commands.
    for (int t = 0; t < 12; t++) begin
      int len;
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        opa[i] = DW'($urandom_range(0, 255));
        opb[i] = DW'($urandom_range(0, 255));
      end
      do_cmd(len, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
